filters_sdiv_seq: RTL and testbench
===================================

Name: filters_sdiv_seq

Overview:
Iterative divider and the inverse of the Filters signed×unsigned multiplier. It takes a signed 32-bit product-domain value and an unsigned 16-bit divisor, and returns a saturated signed 16-bit quotient plus the remainder. Filter normalisation stages use it to scale accumulated products back to sample width. Input and output are each a valid/ready handshake; one division is in flight at a time.

Parameters:
DIVIDEND_W, 32, dividend width (signed)
DIVISOR_W, 16, divisor width (unsigned)
QUOT_W, 16, output quotient width (signed, saturated)

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
in_valid  in  1  dividend/divisor valid
in_ready  out  1  block can accept an operation
dividend  in  DIVIDEND_W  signed dividend
divisor  in  DIVISOR_W  unsigned divisor
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
quotient  out  QUOT_W  signed quotient, saturated
remainder  out  DIVISOR_W+1  signed remainder
ovf  out  1  quotient saturated
div_by_zero  out  1  divisor was 0

Behaviour:
- Reset:
  - state=IDLE; out_valid=0; quotient, remainder, ovf and div_by_zero all 0.
  - in_ready=0 while ap_rst is high; in_ready=1 from the first cycle after reset.
- Handshake: in_ready=(state==IDLE); accept on in_valid&in_ready; output transfer on out_valid&out_ready.
- States:
  - IDLE: on accept (cycle T), latch |dividend|, divisor, dividend sign and zero-divisor flag. Go to CALC with iteration counter 0.
  - CALC: restoring shift-subtract, one quotient bit per cycle, MSB first. Exits after DIVIDEND_W cycles (T+1..T+DIVIDEND_W). Go to FIX.
  - FIX: apply signs, then saturate (filters_div_sat). Register the outputs. Go to DONE.
  - DONE: out_valid=1 from cycle T+DIVIDEND_W+2, so latency is 34 cycles at default widths. Outputs stay stable while out_ready=0. On out_ready go to IDLE; out_valid drops the next cycle. The next accept is possible one cycle after the output transfer.
- Arithmetic (default): C truncating division.
  - Quotient sign = dividend sign. Remainder sign = dividend sign, |remainder| < divisor.
  - The internal quotient is DIVIDEND_W bits and is saturated to [-2^(QUOT_W-1), 2^(QUOT_W-1)-1].
  - ovf=1 iff clipped. -32768 exact is not an overflow.
  - The remainder is always exact, including when ovf=1.
- Divisor 0:
  - CALC still runs the full length, so latency is fixed.
  - quotient = 0x7FFF if dividend≥0, else 0x8000. remainder=0, div_by_zero=1, ovf=0.
- Dividend -2^31: magnitude handled as an unsigned 32-bit value; no wrap.
- Reset mid-operation (any state): abort. Next cycle is IDLE with out_valid=0; no partial result is emitted.
- in_valid while busy is ignored (in_ready=0); inputs are sampled only at accept.

Optional Feature:
FILTERS_SDIV_ROUND_EN.
- Defined:
  - The quotient rounds to nearest, ties away from zero: in FIX, if 2·|rem| ≥ divisor then |q|+1.
  - remainder = dividend − q·divisor, which may have the opposite sign to the dividend.
  - Saturation and ovf are evaluated after rounding. Latency is unchanged.
- Undefined: truncating behaviour only; no rounding logic is present.

Decomposition:
- Package filters_sdiv_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - the default widths;
  - QUOT_MAX/QUOT_MIN saturation constants;
  - the iteration counter width, $clog2(DIVIDEND_W+1).
- Sub-module filters_div_sat is combinational. It takes the unsigned quotient magnitude, the sign and the zero flag, and produces the saturated signed quotient and ovf. It also holds the rounding increment when FILTERS_SDIV_ROUND_EN is defined.

Test Plan:
- Basic: 1000/7 → q=142, rem=6, ovf=0, dz=0; out_valid exactly 34 cycles after accept. With ROUND_EN: q=143, rem=−1.
- Negative: −1000/7 → q=−142, rem=−6. Corner: −2^31/65535 → q=−32768, rem=−32768, ovf=0.
- Saturation: 0x7FFFFFFF/1 → q=0x7FFF, ovf=1. −65536/2 → q=0x8000, ovf=0. −65538/2 → q=0x8000, ovf=1.
- Divide by zero: 5/0 → q=0x7FFF, dz=1. −5/0 → q=0x8000, dz=1, rem=0. Latency still 34.
- Backpressure: hold out_ready=0 for 10 cycles → outputs stable, in_ready=0; new in_valid is not accepted until 1 cycle after the transfer.
- Reset at CALC iteration 10 → next cycle out_valid=0, in_ready=1. A following 1000/7 yields the correct result with no stale data.

Source files
------------

// File: rtl/filters_sdiv_pkg.sv
// -----------------------------------------------------------------------------
// filters_sdiv_pkg
// Shared types and constants for the filters sequential signed divider
// (filters_sdiv_seq) and its quotient saturation stage (filters_div_sat).
//
// Contents:
//   sdiv_state_e    - divider FSM states (IDLE, CALC, FIX, DONE)
//   SDIV_*_W        - default widths of dividend, divisor and quotient
//   QUOT_MAX/MIN    - saturation limits of the default-width signed quotient
//   CNT_W           - width of the iteration counter, $clog2(DIVIDEND_W+1)
//
// Optional feature macro: FILTERS_SDIV_ROUND_EN (see filters_sdiv_seq).
// -----------------------------------------------------------------------------
package filters_sdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } sdiv_state_e;

  localparam int SDIV_DIVIDEND_W = 32;
  localparam int SDIV_DIVISOR_W  = 16;
  localparam int SDIV_QUOT_W     = 16;

  localparam int QUOT_MAX = (2 ** (SDIV_QUOT_W - 1)) - 1;
  localparam int QUOT_MIN = -(2 ** (SDIV_QUOT_W - 1));

  localparam int CNT_W = $clog2(SDIV_DIVIDEND_W + 1);

endpackage

// File: rtl/filters_div_sat.sv
// -----------------------------------------------------------------------------
// filters_div_sat
// Combinational final stage of the signed divider: turns the unsigned quotient
// magnitude into a signed quotient clipped to the QUOT_W range.
//
// Ports:
//   q_mag     in   DIVIDEND_W   unsigned quotient magnitude from the iteration
//   neg       in   1            result is negative (dividend sign)
//   dz        in   1            divisor was zero: force full-scale, no ovf
//   rem_mag   in   DIVISOR_W    remainder magnitude  (FILTERS_SDIV_ROUND_EN only)
//   divisor   in   DIVISOR_W    divisor              (FILTERS_SDIV_ROUND_EN only)
//   round_up  out  1            magnitude was bumped (FILTERS_SDIV_ROUND_EN only)
//   quot      out  QUOT_W       signed saturated quotient
//   ovf       out  1            quotient was clipped
//
// Macro FILTERS_SDIV_ROUND_EN: when defined, the magnitude rounds to nearest
// (ties away from zero) before saturation; otherwise plain truncation.
// -----------------------------------------------------------------------------
module filters_div_sat
  import filters_sdiv_pkg::*;
#(
  parameter int DIVIDEND_W = SDIV_DIVIDEND_W,
  parameter int DIVISOR_W  = SDIV_DIVISOR_W,
  parameter int QUOT_W     = SDIV_QUOT_W
) (
  input  logic [DIVIDEND_W-1:0]    q_mag,
  input  logic                     neg,
  input  logic                     dz,
`ifdef FILTERS_SDIV_ROUND_EN
  input  logic [DIVISOR_W-1:0]     rem_mag,
  input  logic [DIVISOR_W-1:0]     divisor,
  output logic                     round_up,
`endif
  output logic signed [QUOT_W-1:0] quot,
  output logic                     ovf
);

  localparam logic [QUOT_W-1:0] Q_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0] Q_MIN = {1'b1, {(QUOT_W-1){1'b0}}};
  localparam logic [DIVIDEND_W:0] POS_LIM = (DIVIDEND_W+1)'(Q_MAX);
  localparam logic [DIVIDEND_W:0] NEG_LIM = (DIVIDEND_W+1)'(Q_MIN);

  // Returns {ovf, quotient}. The negative side has one more representable
  // magnitude than the positive side, so -2^(QUOT_W-1) exact is not clipped.
  function automatic logic [QUOT_W:0] sat_quot(input logic [DIVIDEND_W:0] mag,
                                               input logic neg_i);
    logic [QUOT_W:0] res;
    if (!neg_i) begin
      if (mag > POS_LIM) res = {1'b1, Q_MAX};
      else               res = {1'b0, mag[QUOT_W-1:0]};
    end else begin
      if (mag > NEG_LIM) res = {1'b1, Q_MIN};
      else               res = {1'b0, QUOT_W'(0) - mag[QUOT_W-1:0]};
    end
    return res;
  endfunction

  logic [DIVIDEND_W:0] mag;
  logic [QUOT_W:0]     sat_res;

`ifdef FILTERS_SDIV_ROUND_EN
  // 2*|rem| >= divisor rounds the magnitude up (ties away from zero).
  always_comb begin
    round_up = !dz && ({rem_mag, 1'b0} >= {1'b0, divisor});
    mag      = {1'b0, q_mag} + {{DIVIDEND_W{1'b0}}, round_up};
  end
`else
  assign mag = {1'b0, q_mag};
`endif

  always_comb begin
    sat_res = sat_quot(mag, neg);
    if (dz) begin
      quot = neg ? Q_MIN : Q_MAX;
      ovf  = 1'b0;
    end else begin
      quot = sat_res[QUOT_W-1:0];
      ovf  = sat_res[QUOT_W];
    end
  end

endmodule

// File: rtl/filters_sdiv_seq.sv
// -----------------------------------------------------------------------------
// filters_sdiv_seq
// Iterative signed/unsigned divider: signed DIVIDEND_W dividend by unsigned
// DIVISOR_W divisor, C-style truncating division, quotient saturated to a
// signed QUOT_W value, remainder exact. Restoring shift-subtract, one quotient
// bit per cycle; fixed latency of DIVIDEND_W+2 cycles from accept to out_valid.
// One operation in flight; valid/ready handshake on both sides.
//
// Ports:
//   ap_clk       in   1             clock
//   ap_rst       in   1             synchronous active-high reset (aborts)
//   in_valid     in   1             dividend/divisor valid
//   in_ready     out  1             idle and able to accept
//   dividend     in   DIVIDEND_W    signed dividend
//   divisor      in   DIVISOR_W     unsigned divisor
//   out_valid    out  1             result valid (held until out_ready)
//   out_ready    in   1             downstream accepts result
//   quotient     out  QUOT_W        signed saturated quotient
//   remainder    out  DIVISOR_W+1   signed remainder
//   ovf          out  1             quotient was saturated
//   div_by_zero  out  1             divisor was zero
//
// Macro FILTERS_SDIV_ROUND_EN: when defined, the quotient rounds to nearest
// (ties away from zero) and remainder = dividend - q*divisor.
// -----------------------------------------------------------------------------
module filters_sdiv_seq
  import filters_sdiv_pkg::*;
#(
  parameter int DIVIDEND_W = SDIV_DIVIDEND_W,
  parameter int DIVISOR_W  = SDIV_DIVISOR_W,
  parameter int QUOT_W     = SDIV_QUOT_W
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]        divisor,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [QUOT_W-1:0]    quotient,
  output logic signed [DIVISOR_W:0]   remainder,
  output logic                        ovf,
  output logic                        div_by_zero
);

  localparam int ITER_W = $clog2(DIVIDEND_W + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DIVIDEND_W - 1);

  sdiv_state_e state_q, state_d;
  logic [ITER_W-1:0]     cnt_q, cnt_d;
  // q_q starts as |dividend| and is shifted out MSB first while quotient
  // bits are shifted in at the bottom; it ends holding |quotient|.
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic                  neg_q, neg_d;
  logic                  dz_q, dz_d;

  logic                        out_valid_q, out_valid_d;
  logic signed [QUOT_W-1:0]    quotient_q, quotient_d;
  logic signed [DIVISOR_W:0]   remainder_q, remainder_d;
  logic                        ovf_q, ovf_d;
  logic                        dzo_q, dzo_d;

  logic [DIVIDEND_W-1:0]     div_u;
  logic [DIVISOR_W:0]        shifted;
  logic [DIVISOR_W:0]        diff;
  logic                      fits;
  logic signed [QUOT_W-1:0]  sat_q;
  logic                      sat_ovf;
  logic signed [DIVISOR_W:0] rem_abs;
  logic signed [DIVISOR_W:0] rem_fix;

`ifdef FILTERS_SDIV_ROUND_EN
  logic round_up;
`endif

  filters_div_sat #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (DIVISOR_W),
    .QUOT_W     (QUOT_W)
  ) u_sat (
    .q_mag    (q_q),
    .neg      (neg_q),
    .dz       (dz_q),
`ifdef FILTERS_SDIV_ROUND_EN
    .rem_mag  (rem_q),
    .divisor  (dvs_q),
    .round_up (round_up),
`endif
    .quot     (sat_q),
    .ovf      (sat_ovf)
  );

  assign in_ready    = (state_q == IDLE) && !ap_rst;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign ovf         = ovf_q;
  assign div_by_zero = dzo_q;

  // Magnitude of the most negative dividend is representable as unsigned.
  assign div_u = dividend;

  // One restoring step: bring down the next dividend bit and trial-subtract.
  always_comb begin
    shifted = {rem_q, q_q[DIVIDEND_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = (shifted >= {1'b0, dvs_q});
  end

  // Signed remainder; a rounded-up quotient overshoots by one divisor.
  always_comb begin
`ifdef FILTERS_SDIV_ROUND_EN
    rem_abs = round_up ? ({1'b0, rem_q} - {1'b0, dvs_q}) : {1'b0, rem_q};
`else
    rem_abs = {1'b0, rem_q};
`endif
    if (dz_q)       rem_fix = '0;
    else if (neg_q) rem_fix = -rem_abs;
    else            rem_fix = rem_abs;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    neg_d       = neg_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    dzo_d       = dzo_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d     = dividend[DIVIDEND_W-1] ? -div_u : div_u;
          rem_d   = '0;
          dvs_d   = divisor;
          neg_d   = dividend[DIVIDEND_W-1];
          dz_d    = (divisor == '0);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // A zero divisor still runs every step so latency never varies.
        rem_d = fits ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
        q_d   = {q_q[DIVIDEND_W-2:0], fits};
        cnt_d = cnt_q + ITER_W'(1);
        if (cnt_q == ITER_LAST) state_d = FIX;
      end
      FIX: begin
        quotient_d  = sat_q;
        ovf_d       = sat_ovf;
        remainder_d = rem_fix;
        dzo_d       = dz_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    // Working registers: only meaningful after an accept, never reset.
    cnt_q <= cnt_d;
    q_q   <= q_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
    neg_q <= neg_d;
    dz_q  <= dz_d;
    if (ap_rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dzo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      dzo_q       <= dzo_d;
    end
  end

endmodule

// File: tb/tb_filters_sdiv_seq.sv
// -----------------------------------------------------------------------------
// tb_filters_sdiv_seq
// Self-checking bench for filters_sdiv_seq. Expected results come from a
// 64-bit reference division model and are queued when an operation is driven,
// then popped and compared when the result appears.
// -----------------------------------------------------------------------------
module tb_filters_sdiv_seq;
  import filters_sdiv_pkg::*;

  localparam int DW  = SDIV_DIVIDEND_W;
  localparam int VW  = SDIV_DIVISOR_W;
  localparam int QW  = SDIV_QUOT_W;
  localparam int LAT = DW + 2;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic signed [DW-1:0]  dividend = '0;
  logic [VW-1:0]         divisor = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic signed [QW-1:0]  quotient;
  logic signed [VW:0]    remainder;
  logic                  ovf;
  logic                  div_by_zero;

  filters_sdiv_seq #(
    .DIVIDEND_W (DW),
    .DIVISOR_W  (VW),
    .QUOT_W     (QW)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .ovf         (ovf),
    .div_by_zero (div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [QW-1:0] q;
    logic signed [VW:0]   r;
    logic                 ovf;
    logic                 dz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t model(input longint a, input longint b);
    exp_t   e;
    longint q;
    longint r;
    longint ra;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    if (b == 0) begin
      q    = (a < 0) ? longint'(QUOT_MIN) : longint'(QUOT_MAX);
      r    = 0;
      e.dz = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
`ifdef FILTERS_SDIV_ROUND_EN
      ra = (r < 0) ? -r : r;
      if (2 * ra >= b) begin
        q = q + ((a < 0) ? -1 : 1);
        r = a - q * b;
      end
`else
      ra = 0;
`endif
      if (q > QUOT_MAX) begin
        q = QUOT_MAX; e.ovf = 1'b1;
      end else if (q < QUOT_MIN) begin
        q = QUOT_MIN; e.ovf = 1'b1;
      end
    end
    e.q = q[QW-1:0];
    e.r = r[VW:0];
    return e;
  endfunction

  // Drives one operation, optionally stalls the output for `stall` cycles,
  // and checks latency, result fields and the post-transfer handshake.
  task automatic run_op(input longint a, input longint b, input int stall,
                        input string tag);
    exp_t e;
    int   t;
    bit   ok;
    out_ready = (stall == 0);
    @(negedge ap_clk);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge ap_clk);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s accept: in_ready got %b required 1", tag, in_ready);
      return;
    end
    dividend = a[DW-1:0];
    divisor  = b[VW-1:0];
    in_valid = 1'b1;
    t        = cyc;
    sb.push_back(model(a, b));
    @(negedge ap_clk);
    in_valid = 1'b0;
    // Junk on the bus must not affect the running operation.
    dividend = 32'sh5A5A_5A5A;
    divisor  = 16'h0003;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge ap_clk);
    end
    e = sb.pop_front();
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s out_valid timeout: got 0 required 1", tag);
      out_ready = 1'b1;
      return;
    end
    n_cmp++;
    if ((cyc - t) !== LAT) begin
      n_bad++;
      $display("FAIL %s latency: got %0d required %0d", tag, cyc - t, LAT);
    end
    n_cmp++;
    if (quotient !== e.q) begin
      n_bad++;
      $display("FAIL %s quotient: got %0d required %0d", tag, quotient, e.q);
    end
    n_cmp++;
    if (remainder !== e.r) begin
      n_bad++;
      $display("FAIL %s remainder: got %0d required %0d", tag, remainder, e.r);
    end
    n_cmp++;
    if (ovf !== e.ovf) begin
      n_bad++;
      $display("FAIL %s ovf: got %b required %b", tag, ovf, e.ovf);
    end
    n_cmp++;
    if (div_by_zero !== e.dz) begin
      n_bad++;
      $display("FAIL %s div_by_zero: got %b required %b", tag, div_by_zero, e.dz);
    end
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      dividend = 32'sd77;
      divisor  = 16'd1;
      @(negedge ap_clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== e.q ||
          remainder !== e.r || ovf !== e.ovf || div_by_zero !== e.dz) begin
        n_bad++;
        $display("FAIL %s stall cycle %0d: got v=%b rdy=%b q=%0d r=%0d required v=1 rdy=0 q=%0d r=%0d",
                 tag, k, out_valid, in_ready, quotient, remainder, e.q, e.r);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge ap_clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s after transfer: got v=%b rdy=%b required v=0 rdy=1",
               tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (3) @(negedge ap_clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset handshake: got rdy=%b v=%b required rdy=0 v=0", in_ready, out_valid);
    end
    n_cmp++;
    if (quotient !== '0 || remainder !== '0 || ovf !== 1'b0 || div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL reset outputs: got q=%0d r=%0d ovf=%b dz=%b required all 0",
               quotient, remainder, ovf, div_by_zero);
    end
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset release: got rdy=%b v=%b required rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    run_op(1000, 7, 0, "basic_1000_7");
    run_op(123456, 100, 0, "basic_123456_100");
    run_op(0, 5, 0, "basic_zero_dividend");
    run_op(65534, 65535, 0, "basic_below_divisor");
  endtask

  task automatic test_negative();
    run_op(-1000, 7, 0, "neg_1000_7");
    run_op(-64'sd2147483648, 65535, 0, "neg_min_65535");
    run_op(-7, 7, 0, "neg_exact");
  endtask

  task automatic test_saturation();
    run_op(64'sd2147483647, 1, 0, "sat_max_by_1");
    run_op(-65536, 2, 0, "sat_min_exact");
    run_op(-65538, 2, 0, "sat_min_over");
    run_op(32767 * 3 + 2, 3, 0, "sat_pos_edge");
    run_op(32768 * 3, 3, 0, "sat_pos_over");
  endtask

  task automatic test_div_zero();
    run_op(5, 0, 0, "dz_pos");
    run_op(-5, 0, 0, "dz_neg");
    run_op(0, 0, 0, "dz_zero");
  endtask

  task automatic test_backpressure();
    run_op(77777, 13, 10, "bp_77777_13");
    run_op(-300, 9, 3, "bp_neg");
  endtask

  task automatic test_back_to_back();
    int     ri;
    longint a;
    longint b;
    for (int i = 0; i < 8; i++) begin
      ri = $urandom();
      a  = ri;
      if (i[0]) a = a >>> 12;
      b  = $urandom_range(0, 65535);
      if (i == 3) b = 1;
      run_op(a, b, 0, "b2b_random");
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    out_ready = 1'b1;
    @(negedge ap_clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid start: in_ready got %b required 1", in_ready);
    end
    dividend = 32'sd999999;
    divisor  = 16'd3;
    in_valid = 1'b1;
    sb.push_back(model(999999, 3));
    @(negedge ap_clk);
    in_valid = 1'b0;
    // Now in the first CALC cycle (iteration 0); advance to iteration 10.
    repeat (10) @(negedge ap_clk);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    void'(sb.pop_back());
    @(negedge ap_clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid abort: got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < LAT + 6; k++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      @(negedge ap_clk);
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL reset_mid stale result: out_valid got 1 required 0");
    end
    run_op(1000, 7, 0, "reset_mid_1000_7");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
